// File: rtl/aes_v1_round_seq.sv
// aes_v1_round_seq: sequences one AES round over an external SubBytes/MixColumns column unit
module aes_v1_round_seq #(
    parameter int DECRYPT_EN = 1
) (
    input  logic         g_clk,
    input  logic         g_resetn,
    input  logic         start,
    input  logic         dec,
    input  logic         last,
    input  logic [127:0] state_in,
    input  logic [127:0] rkey,
    output logic         busy,
    output logic         done,
    output logic [127:0] state_out,
    output logic         cu_valid,
    output logic         cu_dec,
    output logic         cu_mix,
    output logic [31:0]  cu_rs1,
    input  logic         cu_ready,
    input  logic [31:0]  cu_rd
);
    localparam logic [2:0] IDLE = 3'd0, SR = 3'd1, SB = 3'd2, MC = 3'd3, ARK = 3'd4, DONE = 3'd5;
    logic [2:0]   st;
    logic [1:0]   col;
    logic [127:0] w, sr_fwd, sr_inv;
    logic         dec_q, last_q, dec_eff;
    assign dec_eff   = dec && (DECRYPT_EN != 0);
    assign busy      = st != IDLE;
    assign done      = st == DONE;
    assign state_out = w;
    assign cu_valid  = st == SB || st == MC;
    assign cu_mix    = st == MC;
    assign cu_dec    = dec_q;
    assign cu_rs1    = w[32*col +: 32];
    // Row r of column c comes from column c+r (encrypt) or c-r (decrypt).
    genvar c, r;
    for (c = 0; c < 4; c++) begin : g_col
        for (r = 0; r < 4; r++) begin : g_row
            assign sr_fwd[32*c+8*r +: 8] = w[32*((c+r)%4)+8*r +: 8];
            assign sr_inv[32*c+8*r +: 8] = w[32*((c+4-r)%4)+8*r +: 8];
        end
    end
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            st     <= IDLE;
            col    <= '0;
            w      <= '0;
            dec_q  <= 1'b0;
            last_q <= 1'b0;
        end else begin
            case (st)
                IDLE: if (start) begin
                    w      <= state_in;
                    dec_q  <= dec_eff;
                    last_q <= last;
                    col    <= '0;
                    st     <= dec_eff ? SR : SB;
                end
                SR: begin
                    w  <= dec_q ? sr_inv : sr_fwd;
                    st <= dec_q ? SB : (last_q ? ARK : MC);
                end
                SB, MC: if (cu_ready) begin
                    w[32*col +: 32] <= cu_rd;
                    col             <= col + 2'd1;
                    if (col == 2'd3)
                        st <= (st == SB) ? (dec_q ? ARK : SR) : (dec_q ? DONE : ARK);
                end
                ARK: begin
                    w  <= w ^ rkey;
                    st <= (dec_q && !last_q) ? MC : DONE;
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_v1_round_seq.sv
// tb_aes_v1_round_seq: random rounds against a byte-level AES reference, two builds (DECRYPT_EN=1/0)
module tb_aes_v1_round_seq;
    typedef struct packed {
        logic [127:0] v;
        int           due;
    } exp_t;
    logic         g_clk = 1'b0, g_resetn = 1'b0, start = 1'b0, dec = 1'b0, last = 1'b0;
    logic [127:0] state_in = '0, rkey = '0;
    logic [1:0]   busy, done, cu_valid, cu_dec, cu_mix;
    logic [1:0]   cu_ready = 2'b00;
    logic [127:0] st_out [2];
    logic [31:0]  cu_rs1 [2];
    logic [31:0]  cu_rd [2];
    logic [7:0]   sb [256];
    logic [7:0]   isb [256];
    int           cnt [2], rnd [2];
    logic [33:0]  held [2];
    exp_t         q0 [$], q1 [$];
    int           cyc = 0, checks = 0, fails = 0;
    bit           stall_en = 1'b0;
    aes_v1_round_seq #(.DECRYPT_EN(1)) dut0 (
        .g_clk(g_clk), .g_resetn(g_resetn), .start(start), .dec(dec), .last(last),
        .state_in(state_in), .rkey(rkey), .busy(busy[0]), .done(done[0]), .state_out(st_out[0]),
        .cu_valid(cu_valid[0]), .cu_dec(cu_dec[0]), .cu_mix(cu_mix[0]), .cu_rs1(cu_rs1[0]),
        .cu_ready(cu_ready[0]), .cu_rd(cu_rd[0])
    );
    aes_v1_round_seq #(.DECRYPT_EN(0)) dut1 (
        .g_clk(g_clk), .g_resetn(g_resetn), .start(start), .dec(dec), .last(last),
        .state_in(state_in), .rkey(rkey), .busy(busy[1]), .done(done[1]), .state_out(st_out[1]),
        .cu_valid(cu_valid[1]), .cu_dec(cu_dec[1]), .cu_mix(cu_mix[1]), .cu_rs1(cu_rs1[1]),
        .cu_ready(cu_ready[1]), .cu_rd(cu_rd[1])
    );
    always #5 g_clk = ~g_clk;
    always @(posedge g_clk) cyc <= cyc + 1;
    initial begin
        #1_200_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction
    function automatic logic [31:0] mixcol(input logic [31:0] x, input logic inv);
        logic [31:0] o;
        logic [7:0]  b [4];
        for (int i = 0; i < 4; i++) b[i] = x[8*i +: 8];
        for (int i = 0; i < 4; i++)
            o[8*i +: 8] = inv ?
                gmul(b[i], 8'd14) ^ gmul(b[(i+1)%4], 8'd11) ^ gmul(b[(i+2)%4], 8'd13) ^ gmul(b[(i+3)%4], 8'd9) :
                gmul(b[i], 8'd2) ^ gmul(b[(i+1)%4], 8'd3) ^ b[(i+2)%4] ^ b[(i+3)%4];
        return o;
    endfunction
    function automatic logic [31:0] unit(input logic [31:0] x, input logic mix, input logic inv);
        logic [31:0] o;
        for (int i = 0; i < 4; i++) o[8*i +: 8] = inv ? isb[x[8*i +: 8]] : sb[x[8*i +: 8]];
        return mix ? mixcol(x, inv) : o;
    endfunction
    // Whole-round reference: FIPS-197 round on the [row][col] byte matrix.
    function automatic logic [127:0] ref_round(input logic [127:0] s, input logic [127:0] k, input logic d, input logic l);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[32*c+8*r +: 8] = d ? isb[s[32*((c+4-r)%4)+8*r +: 8]] : sb[s[32*((c+r)%4)+8*r +: 8]];
        if (d) o = o ^ k;
        if (!l) for (int c = 0; c < 4; c++) o[32*c +: 32] = mixcol(o[32*c +: 32], d);
        if (!d) o = o ^ k;
        return o;
    endfunction
    function automatic logic [127:0] fips(input logic [127:0] x);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = x[127-8*i -: 8];
        return o;
    endfunction
    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction
    assign cu_rd[0] = unit(cu_rs1[0], cu_mix[0], cu_dec[0]);
    assign cu_rd[1] = unit(cu_rs1[1], cu_mix[1], cu_dec[1]);
    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask
    // Column unit: SubBytes answers after 5 cycles, MixColumns at once, or 0-7 random waits when stalling.
    always @(negedge g_clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!cu_valid[i]) begin
                cnt[i]      = 0;
                cu_ready[i] = 1'b0;
                rnd[i]      = $urandom_range(0, 7);
            end else begin
                if (cnt[i] == 0) held[i] = {cu_rs1[i], cu_mix[i], cu_dec[i]};
                else chk("stall_hold", {94'd0, cu_rs1[i], cu_mix[i], cu_dec[i]}, {94'd0, held[i]});
                if (i == 1) chk("cu_dec_disabled", {127'd0, cu_dec[1]}, 128'd0);
                cu_ready[i] = cnt[i] == (stall_en ? rnd[i] : (cu_mix[i] ? 0 : 4));
                if (cu_ready[i]) begin
                    cnt[i] = 0;
                    rnd[i] = $urandom_range(0, 7);
                end else cnt[i]++;
            end
        end
    end
    always @(negedge g_clk) begin
        exp_t e;
        if (g_resetn) begin
            for (int i = 0; i < 2; i++) begin
                if (done[i]) begin
                    checks++;
                    if ((i == 0 ? q0.size() : q1.size()) == 0) begin
                        fails++;
                        $display("FAIL unexpected_done: dut%0d done=1 at cycle %0d, required 0", i, cyc);
                    end else begin
                        e = (i == 0) ? q0.pop_front() : q1.pop_front();
                        chk(i == 0 ? "result_dut0" : "result_dut1", st_out[i], e.v);
                        if (e.due >= 0) chk(i == 0 ? "done_cycle_dut0" : "done_cycle_dut1", 128'(cyc), 128'(e.due));
                    end
                end
            end
        end
    end
    // Called at a negedge with both builds idle; returns at a negedge with both idle again.
    task automatic issue(input logic [127:0] s, input logic [127:0] k, input logic d, input logic l, input bit timed, input bit junk);
        int n;
        bit ok = 1'b0;
        state_in = s; rkey = k; dec = d; last = l; start = 1'b1; n = cyc;
        q0.push_back('{v: ref_round(s, k, d, l), due: timed ? n + (l ? 23 : 27) : -1});
        q1.push_back('{v: ref_round(s, k, 1'b0, l), due: timed ? n + (l ? 23 : 27) : -1});
        @(negedge g_clk);
        start = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            if (busy == 2'b00 && q0.size() == 0 && q1.size() == 0) begin
                ok = 1'b1;
                break;
            end
            start = junk && busy == 2'b11 && (done[0] || $urandom_range(0, 3) == 0);
            if (junk) begin
                state_in = rnd128();
                dec      = 1'($urandom_range(0, 1));
                last     = 1'($urandom_range(0, 1));
            end
            @(negedge g_clk);
        end
        start = 1'b0;
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL issue_timeout: busy=%b pending=%0d, required idle with no pending results", busy, q0.size() + q1.size());
            g_resetn = 1'b0;
            q0.delete();
            q1.delete();
            @(negedge g_clk);
            g_resetn = 1'b1;
            @(negedge g_clk);
        end
    endtask
    initial begin
        logic [127:0] pt, kt;
        int n;
        for (int x = 0; x < 256; x++) begin
            logic [7:0] b = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
            sb[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) isb[sb[x]] = 8'(x);
        repeat (3) @(negedge g_clk);
        g_resetn = 1'b1;
        @(negedge g_clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_busy", {127'd0, busy[i]}, 128'd0);
            chk("rst_done", {127'd0, done[i]}, 128'd0);
            chk("rst_state_out", st_out[i], 128'd0);
            chk("rst_cu_ctl", {125'd0, cu_valid[i], cu_mix[i], cu_dec[i]}, 128'd0);
            chk("rst_cu_rs1", {96'd0, cu_rs1[i]}, 128'd0);
        end
        pt = fips(128'h193de3bea0f4e22b9ac68d2ae9f84808);
        kt = fips(128'ha0fafe1788542cb123a339392a6c7605);
        issue(pt, kt, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("fips_enc", st_out[0], fips(128'ha49c7ff2689f352b6b5bea43026a5049));
        issue(pt, kt, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("fips_enc_last", st_out[0], fips(128'hd4bf5d30e0b452aeb84111f11e2798e5) ^ kt);
        issue(pt, kt, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("noedec_build_enc", st_out[1], fips(128'ha49c7ff2689f352b6b5bea43026a5049));
        for (int t = 0; t < 150; t++) issue(rnd128(), rnd128(), 1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'(t % 2));
        for (int t = 0; t < 2000; t++) issue(rnd128(), rnd128(), 1'b1, 1'(t / 1000), 1'b1, 1'(t % 2));
        stall_en = 1'b1;
        for (int t = 0; t < 150; t++)
            issue(rnd128(), rnd128(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'(t % 2));
        stall_en = 1'b0;
        state_in = rnd128(); rkey = rnd128(); dec = 1'b0; last = 1'b0; start = 1'b1; n = cyc;
        @(negedge g_clk);
        start = 1'b0;
        while (cyc < n + 3) @(negedge g_clk);
        g_resetn = 1'b0;
        @(negedge g_clk);
        for (int i = 0; i < 2; i++) begin
            chk("abort_busy", {127'd0, busy[i]}, 128'd0);
            chk("abort_cu_valid", {127'd0, cu_valid[i]}, 128'd0);
            chk("abort_state_out", st_out[i], 128'd0);
        end
        g_resetn = 1'b1;
        repeat (40) begin
            @(negedge g_clk);
            chk("abort_quiet", {124'd0, done, cu_valid}, 128'd0);
        end
        issue(pt, kt, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("after_abort_enc", st_out[1], fips(128'ha49c7ff2689f352b6b5bea43026a5049));
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/aes_v1_round_seq.md
AES_V1_ROUND_SEQ -- requirements
Module: aes_v1_round_seq

Interface
REQ-001 SHALL have parameter DECRYPT_EN, default 1, meaning: when 0, dec is ignored and treated as 0.
REQ-002 SHALL have port g_clk  input  1  clock; all logic is on the rising edge.
REQ-003 SHALL have port g_resetn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  input  1  request one AES round.
REQ-005 SHALL have port dec  input  1  0 = encrypt round, 1 = decrypt round.
REQ-006 SHALL have port last  input  1  final round; the MixColumns step is skipped.
REQ-007 SHALL have port state_in  input  128  round input state; FIPS-197 byte k is at [8k+7:8k], column c is at [32c+31:32c], row r is byte r of that column.
REQ-008 SHALL have port rkey  input  128  round key, same layout as state_in, sampled in the ARK step.
REQ-009 SHALL have port busy  output  1  high when not in IDLE.
REQ-010 SHALL have port done  output  1  one-cycle result pulse.
REQ-011 SHALL have port state_out  output  128  working state register.
REQ-012 SHALL have ports cu_valid/cu_dec/cu_mix  output  1 each; cu_rs1  output  32; cu_ready  input  1; cu_rd  input  32. These form the column-unit request/response interface to the AES v1 SubBytes/MixColumns unit.

Function
REQ-013 FSM states SHALL be IDLE, SR, SB, MC, ARK, DONE, with a 2-bit column counter col.
REQ-014 In IDLE with start=1, the block SHALL load state_in into the working register, latch dec (ANDed with DECRYPT_EN) and last, clear col, and leave IDLE.
REQ-015 Encrypt order SHALL be IDLE->SB->SR->MC->ARK->DONE->IDLE; when last=1, SR SHALL go directly to ARK.
REQ-016 Decrypt order SHALL be IDLE->SR->SB->ARK->MC->DONE->IDLE; when last=1, ARK SHALL go directly to DONE.
REQ-017 SR SHALL take 1 cycle. Encrypt: new[c][r]=old[(c+r)%4][r]. Decrypt: new[c][r]=old[(c-r)%4][r].
REQ-018 In SB and MC: cu_valid=1, cu_rs1=column col, cu_mix=(state==MC), cu_dec=latched dec; cu_valid SHALL be 0 in every other state.
REQ-019 In a cycle with cu_valid=1 and cu_ready=1, the block SHALL write cu_rd into column col and increment col; when col==3 it SHALL clear col and advance the FSM.
REQ-020 While cu_valid=1 and cu_ready=0, the block SHALL hold cu_rs1, cu_mix and cu_dec stable; there is no timeout.
REQ-021 cu_ready SHALL be ignored when cu_valid=0.
REQ-022 ARK SHALL take 1 cycle: working register ^= rkey.
REQ-023 DONE SHALL assert done for exactly 1 cycle and then return to IDLE.
REQ-024 state_out SHALL hold its value from DONE until the next accepted start.
REQ-025 start SHALL be ignored while busy=1; dec, last and state_in SHALL be sampled only at acceptance.
REQ-026 With a unit that answers SubBytes in 5 cycles and MixColumns in the same cycle, done SHALL be high in cycle N+27 when start is accepted in cycle N and last=0, and in N+23 when last=1, for both dec values.
REQ-027 start high in the DONE cycle SHALL be ignored; the earliest next acceptance is the following IDLE cycle.

Reset
REQ-028 When g_resetn=0 at a clock edge: FSM SHALL go to IDLE, col=0, working register=0, latched dec/last=0.
REQ-029 Reset applied mid-operation SHALL abort the round, with no done pulse and no further cu_valid.
REQ-030 After reset and before the first start, outputs SHALL be busy=0, done=0, state_out=0, cu_valid=0, cu_mix=0, cu_dec=0, cu_rs1=0.

Verification
REQ-031 Encrypt test: dec=0, last=0, state_in=193de3bea0f4e22b9ac68d2ae9f84808, rkey=a0fafe1788542cb123a339392a6c7605 (FIPS byte order) -> done at N+27, state_out=a49c7ff2689f352b6b5bea43026a5049.
REQ-032 Encrypt last-round test: same inputs with last=1 -> done at N+23, state_out=SR(SB(state_in))^rkey = d4bf5d30e0b452aeb84111f11e2798e5 ^ rkey.
REQ-033 Decrypt tests: dec=1, last=0 and last=1, 1000 random state/key pairs -> state_out matches the software reference model; done at N+27 / N+23.
REQ-034 Stall test: a unit model inserts 0-7 random wait cycles per request -> cu_rs1/cu_mix/cu_dec stay stable while waiting, and the result is identical to the no-stall result.
REQ-035 Control test: start pulsed during busy and in the DONE cycle is ignored. g_resetn=0 in an SB cycle -> next cycle busy=0, cu_valid=0, state_out=0, with no done pulse.
REQ-036 DECRYPT_EN=0 build with dec=1 -> cu_dec stays 0 and the result equals the encrypt result.
